// File: rtl/ir_beacon_detect.sv
// IR goal-beacon front end: synchronises the IR pin, measures rising-edge periods
// and confirms 1 kHz / 10 kHz beacons. Define IR_HYST_EN to hold flags through misses.
module ir_beacon_detect #(
  parameter int unsigned P1K_MIN  = 90_000,
  parameter int unsigned P1K_MAX  = 110_000,
  parameter int unsigned P10K_MIN = 9_000,
  parameter int unsigned P10K_MAX = 11_000,
  parameter int unsigned CONFIRM  = 4,
  parameter int unsigned TIMEOUT  = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable,
  input  logic        IR_In,
  output logic        IR_1k,
  output logic        IR_10k,
  output logic [17:0] Period,
  output logic        Period_Valid
);

  typedef enum logic [1:0] {ST_DISABLED, ST_ARM, ST_MEASURE} state_t;
  typedef enum logic [1:0] {CL_NONE, CL_1K, CL_10K} class_t;

  localparam logic [17:0] CNT_MAX = '1;
  localparam logic [17:0] TO_CNT  = 18'(TIMEOUT);
  localparam logic [3:0]  CONF    = 4'(CONFIRM);

  logic [2:0]  sync_q;
  logic        edge_q;
  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] period_q, period_d;
  logic        valid_q, valid_d;
  class_t      class_q, class_d;
  logic [3:0]  match_q, match_d;
  logic [17:0] cnt_inc;
  class_t      cls;
`ifdef IR_HYST_EN
  class_t      held_q, held_d;
  logic [3:0]  miss_q, miss_d;
  class_t      hit;
`endif

  function automatic class_t classify(input logic [17:0] p);
    if (p >= 18'(P1K_MIN) && p <= 18'(P1K_MAX))
      return CL_1K;
    else if (p >= 18'(P10K_MIN) && p <= 18'(P10K_MAX))
      return CL_10K;
    else
      return CL_NONE;
  endfunction

  // sync_q[1] is the metastability-safe sample; sync_q[2] is its delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], IR_In};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    class_d  = class_q;
    match_d  = match_q;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 18'd1;
    cls      = classify(cnt_q);
`ifdef IR_HYST_EN
    held_d   = held_q;
    miss_d   = miss_q;
    hit      = CL_NONE;
`endif
    unique case (state_q)
      ST_DISABLED: begin
        cnt_d   = '0;
        class_d = CL_NONE;
        match_d = '0;
        if (Enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        cnt_d = cnt_inc;
        if (edge_q) begin
          cnt_d   = 18'd1;
          state_d = ST_MEASURE;
        end else if (cnt_q >= TO_CNT) begin
          cnt_d = 18'd1;
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_inc;
        if (edge_q) begin
          // Restarting at 1 counts the capture cycle, so Period equals the edge spacing.
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = 18'd1;
          if (cls == CL_NONE) begin
            class_d = CL_NONE;
            match_d = '0;
          end else if (cls == class_q) begin
            match_d = (match_q == CONF) ? CONF : match_q + 4'd1;
          end else begin
            class_d = cls;
            match_d = 4'd1;
          end
`ifdef IR_HYST_EN
          hit = (match_d == CONF) ? class_d : CL_NONE;
          if (hit != CL_NONE && hit != held_q) begin
            held_d = hit;
            miss_d = '0;
          end else if (held_q != CL_NONE) begin
            if (cls == held_q) begin
              miss_d = '0;
            end else if (miss_q + 4'd1 == CONF) begin
              held_d = CL_NONE;
              miss_d = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
`endif
        end else if (cnt_q >= TO_CNT) begin
          class_d = CL_NONE;
          match_d = '0;
          cnt_d   = 18'd1;
          state_d = ST_ARM;
`ifdef IR_HYST_EN
          held_d  = CL_NONE;
          miss_d  = '0;
`endif
        end
      end
      default: state_d = ST_DISABLED;
    endcase
    // Disable overrides everything, including a coincident edge.
    if (!Enable) begin
      state_d  = ST_DISABLED;
      cnt_d    = '0;
      period_d = period_q;
      valid_d  = 1'b0;
      class_d  = CL_NONE;
      match_d  = '0;
`ifdef IR_HYST_EN
      held_d   = CL_NONE;
      miss_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DISABLED;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      class_q  <= CL_NONE;
      match_q  <= '0;
`ifdef IR_HYST_EN
      held_q   <= CL_NONE;
      miss_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      class_q  <= class_d;
      match_q  <= match_d;
`ifdef IR_HYST_EN
      held_q   <= held_d;
      miss_q   <= miss_d;
`endif
    end
  end

`ifdef IR_HYST_EN
  assign IR_1k  = (held_q == CL_1K);
  assign IR_10k = (held_q == CL_10K);
`else
  assign IR_1k  = (class_q == CL_1K)  && (match_q == CONF);
  assign IR_10k = (class_q == CL_10K) && (match_q == CONF);
`endif
  assign Period       = period_q;
  assign Period_Valid = valid_q;

endmodule

// File: tb/tb_ir_beacon_detect.sv
// Directed bench for ir_beacon_detect; thresholds scaled down by 100 so a 1 kHz
// beacon is a 1000-cycle period and every scenario stays short.
module tb_ir_beacon_detect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Enable = 1'b0;
  logic        IR_In = 1'b0;
  logic        IR_1k, IR_10k, Period_Valid;
  logic [17:0] Period;

  int n_cmp = 0;
  int n_bad = 0;

  ir_beacon_detect #(
    .P1K_MIN(900), .P1K_MAX(1100), .P10K_MIN(90), .P10K_MAX(110),
    .CONFIRM(4), .TIMEOUT(2500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .IR_In(IR_In),
    .IR_1k(IR_1k), .IR_10k(IR_10k), .Period(Period), .Period_Valid(Period_Valid)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // One rising edge followed by a square-wave period of per cycles; reports the
  // Period_Valid pulse (if any) and the flags seen within 8 cycles of the edge.
  task automatic pulse(input int per, output bit got, output logic [17:0] per_o,
                       output logic f1, output logic f10);
    got = 1'b0; per_o = '0; f1 = 1'b0; f10 = 1'b0;
    IR_In = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Period_Valid === 1'b1 && !got) begin
        got = 1'b1; per_o = Period; f1 = IR_1k; f10 = IR_10k;
      end
    end
    if (!got) begin f1 = IR_1k; f10 = IR_10k; end
    repeat (per / 2 - 8) @(negedge clk);
    IR_In = 1'b0;
    repeat (per - per / 2) @(negedge clk);
  endtask

  task automatic reenable();
    Enable = 1'b0;
    repeat (3) @(negedge clk);
    Enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Enable = 1'b0; IR_In = 1'b0;
    #25;
    n_cmp++; if (IR_1k !== 1'b0) begin n_bad++; $display("FAIL reset_ir1k: got %b want 0", IR_1k); end
    n_cmp++; if (IR_10k !== 1'b0) begin n_bad++; $display("FAIL reset_ir10k: got %b want 0", IR_10k); end
    n_cmp++; if (Period !== 18'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", Period); end
    n_cmp++; if (Period_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", Period_Valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_1k();
    bit g; logic [17:0] p; logic f1, f10;
    Enable = 1'b1;
    repeat (5) @(negedge clk);
    for (int e = 1; e <= 6; e++) begin
      pulse(1000, g, p, f1, f10);
      if (e == 1) begin
        n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL 1k_first_edge_valid: got %b want 0", g); end
      end else begin
        n_cmp++; if (g !== 1'b1 || p !== 18'd1000) begin n_bad++; $display("FAIL 1k_period e%0d: got v=%b p=%0d want v=1 p=1000", e, g, p); end
        n_cmp++; if (f1 !== (e >= 5) || f10 !== 1'b0) begin n_bad++; $display("FAIL 1k_flags e%0d: got 1k=%b 10k=%b want 1k=%b 10k=0", e, f1, f10, e >= 5); end
      end
    end
  endtask

  task automatic test_timeout();
    bit g; logic [17:0] p; logic f1, f10;
    int waited = 0;
    bit saw_v = 1'b0;
    n_cmp++; if (IR_1k !== 1'b1) begin n_bad++; $display("FAIL timeout_locked: got %b want 1", IR_1k); end
    while (IR_1k === 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (Period_Valid === 1'b1) saw_v = 1'b1;
    end
    n_cmp++; if (IR_1k !== 1'b0) begin n_bad++; $display("FAIL timeout_drop: got %b want 0 within 3000 cycles", IR_1k); end
    n_cmp++; if (waited < 1450 || waited > 1550) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles want 1450..1550", waited); end
    n_cmp++; if (saw_v !== 1'b0) begin n_bad++; $display("FAIL timeout_no_valid: got %b want 0", saw_v); end
    for (int e = 1; e <= 5; e++) begin
      pulse(1000, g, p, f1, f10);
      if (e == 1) begin
        n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL resume_first_valid: got %b want 0", g); end
      end else begin
        n_cmp++; if (g !== 1'b1 || p !== 18'd1000 || f1 !== (e == 5)) begin
          n_bad++; $display("FAIL resume_e%0d: got v=%b p=%0d 1k=%b want v=1 p=1000 1k=%b", e, g, p, f1, e == 5);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit g; logic [17:0] p; logic f1, f10;
    pulse(500, g, p, f1, f10);
    n_cmp++; if (g !== 1'b1 || p !== 18'd1000 || f1 !== 1'b1) begin n_bad++; $display("FAIL glitch_pre: got v=%b p=%0d 1k=%b want v=1 p=1000 1k=1", g, p, f1); end
`ifdef IR_HYST_EN
    for (int j = 1; j <= 4; j++) begin
      pulse((j < 4) ? 500 : 1000, g, p, f1, f10);
      n_cmp++; if (g !== 1'b1 || p !== 18'd500 || f1 !== (j < 4)) begin
        n_bad++; $display("FAIL hyst_bad%0d: got v=%b p=%0d 1k=%b want v=1 p=500 1k=%b", j, g, p, f1, j < 4);
      end
    end
`else
    for (int j = 1; j <= 5; j++) begin
      pulse(1000, g, p, f1, f10);
      n_cmp++; if (g !== 1'b1 || p !== ((j == 1) ? 18'd500 : 18'd1000) || f1 !== (j == 5)) begin
        n_bad++; $display("FAIL glitch_j%0d: got v=%b p=%0d 1k=%b want v=1 p=%0d 1k=%b", j, g, p, f1, (j == 1) ? 500 : 1000, j == 5);
      end
    end
`endif
  endtask

  task automatic test_10k();
    bit g; logic [17:0] p; logic f1, f10;
    Enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (IR_1k !== 1'b0 || IR_10k !== 1'b0) begin n_bad++; $display("FAIL disabled_flags: got 1k=%b 10k=%b want 0 0", IR_1k, IR_10k); end
    Enable = 1'b1;
    repeat (3) @(negedge clk);
    for (int e = 1; e <= 6; e++) begin
      pulse(100, g, p, f1, f10);
      if (e == 1) begin
        n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL 10k_first_valid: got %b want 0", g); end
      end else begin
        n_cmp++; if (g !== 1'b1 || p !== 18'd100 || f10 !== (e >= 5) || f1 !== 1'b0) begin
          n_bad++; $display("FAIL 10k_e%0d: got v=%b p=%0d 1k=%b 10k=%b want v=1 p=100 1k=0 10k=%b", e, g, p, f1, f10, e >= 5);
        end
      end
    end
  endtask

  task automatic test_enable();
    bit g; logic [17:0] p; logic f1, f10;
    n_cmp++; if (IR_10k !== 1'b1) begin n_bad++; $display("FAIL enable_pre: got 10k=%b want 1", IR_10k); end
    Enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (IR_10k !== 1'b0) begin n_bad++; $display("FAIL enable_drop: got 10k=%b want 0", IR_10k); end
    Enable = 1'b1;
    repeat (3) @(negedge clk);
    pulse(100, g, p, f1, f10);
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL reenable_first_valid: got %b want 0", g); end
    pulse(100, g, p, f1, f10);
    n_cmp++; if (g !== 1'b1 || p !== 18'd100 || f10 !== 1'b0) begin n_bad++; $display("FAIL reenable_second: got v=%b p=%0d 10k=%b want v=1 p=100 10k=0", g, p, f10); end
  endtask

  task automatic test_5k();
    bit g; logic [17:0] p; logic f1, f10;
    reenable();
    for (int e = 1; e <= 5; e++) begin
      pulse(200, g, p, f1, f10);
      if (e > 1) begin
        n_cmp++; if (g !== 1'b1 || p !== 18'd200 || f1 !== 1'b0 || f10 !== 1'b0) begin
          n_bad++; $display("FAIL 5k_e%0d: got v=%b p=%0d 1k=%b 10k=%b want v=1 p=200 0 0", e, g, p, f1, f10);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    bit g; logic [17:0] p; logic f1, f10;
    reenable();
    for (int e = 1; e <= 5; e++) pulse(1000, g, p, f1, f10);
    n_cmp++; if (f1 !== 1'b1) begin n_bad++; $display("FAIL rst_mid_lock: got 1k=%b want 1", f1); end
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (IR_1k !== 1'b0 || IR_10k !== 1'b0 || Period !== 18'd0 || Period_Valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_async: got 1k=%b 10k=%b p=%0d v=%b want 0 0 0 0", IR_1k, IR_10k, Period, Period_Valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(1000, g, p, f1, f10);
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL rst_mid_first_valid: got %b want 0", g); end
    pulse(1000, g, p, f1, f10);
    n_cmp++; if (g !== 1'b1 || p !== 18'd1000 || f1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_second: got v=%b p=%0d 1k=%b want v=1 p=1000 1k=0", g, p, f1); end
  endtask

  task automatic test_back_to_back();
    bit saw_v = 1'b0;
    IR_In = 1'b1;
    repeat (3) @(negedge clk);
    Enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Period_Valid === 1'b1) saw_v = 1'b1;
    end
    n_cmp++; if (saw_v !== 1'b0) begin n_bad++; $display("FAIL disable_vs_edge_valid: got %b want 0", saw_v); end
    n_cmp++; if (Period !== 18'd1000) begin n_bad++; $display("FAIL disable_vs_edge_period: got %0d want 1000", Period); end
    IR_In = 1'b0;
  endtask

  initial begin
    test_reset();
    test_1k();
    test_timeout();
    test_glitch();
    test_10k();
    test_enable();
    test_5k();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
